npc_deadtime_gen: RTL and testbench
===================================

Name: npc_deadtime_gen

Overview:
- Parametrised multi-leg dead-time generator for three-level NPC inverter legs; successor to the fixed three-leg NPC dead-time block.
- Takes a per-leg level command (P/O/N) and drives the four gate signals of each leg.
- Enforces NPC-legal sequencing: P and N transitions always pass through O, with a programmable dead time and a minimum level dwell.
- Provides enable/fault-driven controlled shutdown (outer switches off before inner) and status flags.
- Sits between the modulator/state decoder and the gate-driver outputs.

Parameters:
- N_LEGS, 3, number of inverter legs.
- DT_WIDTH, 8, width of the dead-time count port and the internal down-counter.
- MIN_DWELL, 4, minimum cycles a leg holds a steady level (P/O/N) before its next transition; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  run enable; 0 requests a controlled shutdown, not latched.
- dt_cycles  in  DT_WIDTH  dead time in clk cycles. Sampled on each dead-interval entry. 0 is treated as 1.
- leg_cmd  in  2*N_LEGS  per-leg command; leg i uses bits [2i+1:2i]. 00=N, 01=O, 10=P, 11=invalid.
- fault  in  1  external fault, active high.
- fault_clr  in  1  clears latched fault and cmd_err.
- gate  out  4*N_LEGS  leg i uses bits [4i+3:4i] = {S1,S2,S3,S4}.
- level  out  2*N_LEGS  applied steady level per leg, same encoding as leg_cmd. Holds the last steady level during dead intervals; reads 01 when OFF.
- busy  out  N_LEGS  leg is in a dead interval or shutdown sequence.
- fault_active  out  1  latched fault.
- cmd_err  out  N_LEGS  sticky per-leg invalid-command flag.

Behaviour:
- Gate patterns:
  - P=1100, O=0110, N=0011.
  - Dead P<->O = 0100 (S2 only). Dead O<->N = 0010 (S3 only).
  - OFF=0000.
- All outputs are registered.
- Reset (rst_n=0 at a clk edge): every leg goes to OFF, gate=0, level=01, busy=0, fault_active=0, cmd_err=0, counters cleared.
- Per-leg FSM states: OFF, LVL_P, LVL_O, LVL_N, DT_PO, DT_OP, DT_ON, DT_NO, SD_P, SD_N.
- Shutdown request: sd = ~en | fault_active.
- OFF: if sd=0, go to LVL_O on the next edge (gate 0110) and the dwell counter restarts.
- LVL_x: the dwell counter counts up to MIN_DWELL. Once it is satisfied and the sampled command differs from x, step one level toward the command:
  - P->O: DT_PO. O->N: DT_ON. N->O: DT_NO. O->P: DT_OP.
  - A P->N command goes P->DT_PO->O (with dwell)->DT_ON->N. N->P is the mirror image.
  - On entry to any DT_*, the dead counter loads max(dt_cycles,1).
- DT_*: outputs the dead pattern while the counter decrements.
  - When it reaches 1, the next edge enters the target LVL and the dwell counter resets.
  - Commands are ignored during dead intervals and re-evaluated after the dwell.
- Timing: command sampled at edge k (dwell satisfied) -> dead pattern visible after edge k -> new level visible after edge k+D, where D=max(dt,1).
  - Full P->N: N is visible after edge k+2D+MIN_DWELL.
- Invalid command (11) in LVL_x: hold the current level, set cmd_err[i] (sticky).
- Shutdown (sd=1) has priority over commands:
  - LVL_P: go to SD_P (0100), wait D, then OFF.
  - LVL_N: go to SD_N (0010), wait D, then OFF.
  - LVL_O: go to OFF on the next edge.
  - DT_*: finish the remaining count, then OFF.
  - busy=1 throughout SD_*.
- If sd drops during SD_*, the sequence still completes to OFF, then restarts via OFF->LVL_O.
- fault=1 at any edge sets fault_active.
- fault_clr=1 with fault=0 clears fault_active and all cmd_err bits. fault and fault_clr asserted together: fault wins.
- Invariants, never produced on any cycle: S1&S3, S2&S4, S1&~S2, S4&~S3.
- Legs are independent and share only dt_cycles, en and the fault logic.

Test Plan:
- Reset then en=1, leg_cmd all 01, dt=5 -> all legs 0110 one cycle after reset release; level=01; busy=0.
- Leg0 cmd O->P, dt=5, dwell satisfied -> 0100 for 5 cycles, then 1100; busy high exactly 5 cycles; level changes to 10 when 1100 appears.
- Leg1 cmd P->N directly, dt=3, MIN_DWELL=4 -> 0100 x3, 0110 x4, 0010 x3, then 0011 (total 10 cycles to N); no forbidden pattern on any cycle.
- dt_cycles=0 -> every dead interval lasts exactly 1 cycle. Command toggling every cycle -> level changes no faster than every 1+MIN_DWELL cycles.
- fault pulse of 1 cycle while legs are at P/O/N with dt=4:
  - P leg: 0100 x4 then 0000. O leg: 0000 next cycle. N leg: 0010 x4 then 0000.
  - fault_active stays set; fault_clr with fault=0 -> legs return to 0110.
- leg_cmd=11 on leg2 -> gate holds its level, cmd_err[2]=1 persists after a valid command; fault_clr clears it. rst_n=0 mid-dead -> all gates 0000 on the next edge.

Source files
------------

// File: rtl/npc_deadtime_gen.sv
// Multi-leg three-level NPC dead-time generator: per-leg P/O/N sequencing through O with
// programmable dead time, minimum level dwell, controlled shutdown and sticky status flags.
module npc_deadtime_gen #(
    parameter int unsigned N_LEGS    = 3,
    parameter int unsigned DT_WIDTH  = 8,
    parameter int unsigned MIN_DWELL = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [DT_WIDTH-1:0]   i_dt_cycles,
    input  logic [2*N_LEGS-1:0]   i_leg_cmd,
    input  logic                  i_fault,
    input  logic                  i_fault_clr,
    output logic [4*N_LEGS-1:0]   o_gate,
    output logic [2*N_LEGS-1:0]   o_level,
    output logic [N_LEGS-1:0]     o_busy,
    output logic                  o_fault_active,
    output logic [N_LEGS-1:0]     o_cmd_err
);

    localparam int unsigned      DW_W      = $clog2(MIN_DWELL + 1);
    localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(MIN_DWELL);
    localparam logic [1:0]       CMD_N     = 2'b00;
    localparam logic [1:0]       CMD_O     = 2'b01;
    localparam logic [1:0]       CMD_P     = 2'b10;
    localparam logic [1:0]       CMD_BAD   = 2'b11;

    typedef enum logic [3:0] {
        StOff, StLvlP, StLvlO, StLvlN, StDtPo, StDtOp, StDtOn, StDtNo, StSdP, StSdN
    } state_e;

    state_e               r_state   [N_LEGS];
    state_e               w_state_d [N_LEGS];
    logic [DW_W-1:0]      r_dwell   [N_LEGS];
    logic [DW_W-1:0]      w_dwell_d [N_LEGS];
    logic [DT_WIDTH-1:0]  r_dead    [N_LEGS];
    logic [DT_WIDTH-1:0]  w_dead_d  [N_LEGS];

    logic                 r_fault_active;
    logic                 w_fault_active_d;
    logic [N_LEGS-1:0]    r_cmd_err;
    logic [N_LEGS-1:0]    w_cmd_err_d;
    logic [4*N_LEGS-1:0]  r_gate;
    logic [2*N_LEGS-1:0]  r_level;
    logic [N_LEGS-1:0]    r_busy;

    logic                 w_sd;
    logic [DT_WIDTH-1:0]  w_dt_load;

    assign w_sd      = ~i_en | r_fault_active;
    assign w_dt_load = (i_dt_cycles == '0) ? DT_WIDTH'(1) : i_dt_cycles;

    function automatic logic is_lvl(input state_e s);
        return (s == StLvlP) || (s == StLvlO) || (s == StLvlN);
    endfunction

    function automatic logic [3:0] gate_of(input state_e s);
        logic [3:0] g;
        unique case (s)
            StLvlP:                 g = 4'b1100;
            StLvlO:                 g = 4'b0110;
            StLvlN:                 g = 4'b0011;
            StDtPo, StDtOp, StSdP:  g = 4'b0100;
            StDtOn, StDtNo, StSdN:  g = 4'b0010;
            default:                g = 4'b0000;
        endcase
        return g;
    endfunction

    // Dead and shutdown states report the steady level they are leaving.
    function automatic logic [1:0] level_of(input state_e s);
        logic [1:0] l;
        unique case (s)
            StLvlP, StDtPo, StSdP:  l = CMD_P;
            StLvlN, StDtNo, StSdN:  l = CMD_N;
            default:                l = CMD_O;
        endcase
        return l;
    endfunction

    always_comb begin
        for (int i = 0; i < N_LEGS; i++) begin
            w_state_d[i] = r_state[i];
            w_dwell_d[i] = r_dwell[i];
            w_dead_d[i]  = r_dead[i];
            if (is_lvl(r_state[i]) && (r_dwell[i] != DWELL_MAX)) begin
                w_dwell_d[i] = r_dwell[i] + DW_W'(1);
            end
            unique case (r_state[i])
                StOff: begin
                    if (!w_sd) begin
                        w_state_d[i] = StLvlO;
                        w_dwell_d[i] = DW_W'(1);
                    end
                end
                StLvlP: begin
                    if (w_sd) begin
                        w_state_d[i] = StSdP;
                        w_dead_d[i]  = w_dt_load;
                    end else if ((r_dwell[i] == DWELL_MAX) &&
                                 ((i_leg_cmd[2*i +: 2] == CMD_O) ||
                                  (i_leg_cmd[2*i +: 2] == CMD_N))) begin
                        w_state_d[i] = StDtPo;
                        w_dead_d[i]  = w_dt_load;
                    end
                end
                StLvlO: begin
                    if (w_sd) begin
                        w_state_d[i] = StOff;
                    end else if ((r_dwell[i] == DWELL_MAX) && (i_leg_cmd[2*i +: 2] == CMD_P)) begin
                        w_state_d[i] = StDtOp;
                        w_dead_d[i]  = w_dt_load;
                    end else if ((r_dwell[i] == DWELL_MAX) && (i_leg_cmd[2*i +: 2] == CMD_N)) begin
                        w_state_d[i] = StDtOn;
                        w_dead_d[i]  = w_dt_load;
                    end
                end
                StLvlN: begin
                    if (w_sd) begin
                        w_state_d[i] = StSdN;
                        w_dead_d[i]  = w_dt_load;
                    end else if ((r_dwell[i] == DWELL_MAX) &&
                                 ((i_leg_cmd[2*i +: 2] == CMD_O) ||
                                  (i_leg_cmd[2*i +: 2] == CMD_P))) begin
                        w_state_d[i] = StDtNo;
                        w_dead_d[i]  = w_dt_load;
                    end
                end
                StDtPo, StDtOp, StDtOn, StDtNo: begin
                    if (r_dead[i] <= DT_WIDTH'(1)) begin
                        w_dwell_d[i] = DW_W'(1);
                        if (w_sd) begin
                            w_state_d[i] = StOff;
                        end else if (r_state[i] == StDtOp) begin
                            w_state_d[i] = StLvlP;
                        end else if (r_state[i] == StDtOn) begin
                            w_state_d[i] = StLvlN;
                        end else begin
                            w_state_d[i] = StLvlO;
                        end
                    end else begin
                        w_dead_d[i] = r_dead[i] - DT_WIDTH'(1);
                    end
                end
                StSdP, StSdN: begin
                    if (r_dead[i] <= DT_WIDTH'(1)) begin
                        w_state_d[i] = StOff;
                    end else begin
                        w_dead_d[i] = r_dead[i] - DT_WIDTH'(1);
                    end
                end
                default: w_state_d[i] = StOff;
            endcase
        end
    end

    always_comb begin
        w_fault_active_d = r_fault_active;
        w_cmd_err_d      = r_cmd_err;
        if (i_fault) begin
            w_fault_active_d = 1'b1;
        end else if (i_fault_clr) begin
            w_fault_active_d = 1'b0;
            w_cmd_err_d      = '0;
        end
        for (int i = 0; i < N_LEGS; i++) begin
            if (is_lvl(r_state[i]) && (i_leg_cmd[2*i +: 2] == CMD_BAD)) begin
                w_cmd_err_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_LEGS; i++) begin
                r_state[i]           <= StOff;
                r_dwell[i]           <= '0;
                r_dead[i]            <= '0;
                r_gate[4*i +: 4]     <= 4'b0000;
                r_level[2*i +: 2]    <= CMD_O;
                r_busy[i]            <= 1'b0;
            end
            r_fault_active <= 1'b0;
            r_cmd_err      <= '0;
        end else begin
            for (int i = 0; i < N_LEGS; i++) begin
                r_state[i]           <= w_state_d[i];
                r_dwell[i]           <= w_dwell_d[i];
                r_dead[i]            <= w_dead_d[i];
                r_gate[4*i +: 4]     <= gate_of(w_state_d[i]);
                r_level[2*i +: 2]    <= level_of(w_state_d[i]);
                r_busy[i]            <= (w_state_d[i] != StOff) && !is_lvl(w_state_d[i]);
            end
            r_fault_active <= w_fault_active_d;
            r_cmd_err      <= w_cmd_err_d;
        end
    end

    assign o_gate         = r_gate;
    assign o_level        = r_level;
    assign o_busy         = r_busy;
    assign o_fault_active = r_fault_active;
    assign o_cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_npc_deadtime_gen.sv
// Directed bench for npc_deadtime_gen: a cycle table for reset/startup and O->P, then
// hand sequences for P->N, zero dead time, fault shutdown, invalid commands and reset.
module tb_npc_deadtime_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  dt;
    logic [5:0]  cmd;
    logic        fault;
    logic        fault_clr;
    logic [11:0] gate;
    logic [5:0]  level;
    logic [2:0]  busy;
    logic        fa;
    logic [2:0]  err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    npc_deadtime_gen #(
        .N_LEGS    (3),
        .DT_WIDTH  (8),
        .MIN_DWELL (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .i_dt_cycles    (dt),
        .i_leg_cmd      (cmd),
        .i_fault        (fault),
        .i_fault_clr    (fault_clr),
        .o_gate         (gate),
        .o_level        (level),
        .o_busy         (busy),
        .o_fault_active (fa),
        .o_cmd_err      (err)
    );

    typedef struct {
        logic        rst_n;
        logic [7:0]  dt;
        logic [5:0]  cmd;
        logic [11:0] gate;
        logic [5:0]  level;
        logic [2:0]  busy;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later and screen for forbidden gate states.
    task automatic tick();
        logic [3:0] g;
        logic       bad;
        @(posedge clk);
        #1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            g = gate[4*i +: 4];
            if ((g[3] & g[1]) | (g[2] & g[0]) | (g[3] & ~g[2]) | (g[0] & ~g[1])) bad = 1'b1;
        end
        chk("invariant", {31'd0, bad}, 32'd0);
    endtask

    logic [3:0] exp_g [11];
    logic [1:0] exp_l [11];
    logic       exp_b [11];

    initial begin
        rst_n = 1'b0; en = 1'b1; dt = 8'd5; cmd = 6'h15; fault = 1'b0; fault_clr = 1'b0;

        vecs[0]  = '{1'b0, 8'd5, 6'h15, 12'h000, 6'h15, 3'b000};
        vecs[1]  = '{1'b1, 8'd5, 6'h15, 12'h666, 6'h15, 3'b000};
        vecs[2]  = '{1'b1, 8'd5, 6'h15, 12'h666, 6'h15, 3'b000};
        vecs[3]  = '{1'b1, 8'd5, 6'h15, 12'h666, 6'h15, 3'b000};
        vecs[4]  = '{1'b1, 8'd5, 6'h15, 12'h666, 6'h15, 3'b000};
        vecs[5]  = '{1'b1, 8'd5, 6'h16, 12'h664, 6'h15, 3'b001};
        vecs[6]  = '{1'b1, 8'd5, 6'h16, 12'h664, 6'h15, 3'b001};
        vecs[7]  = '{1'b1, 8'd5, 6'h16, 12'h664, 6'h15, 3'b001};
        vecs[8]  = '{1'b1, 8'd5, 6'h16, 12'h664, 6'h15, 3'b001};
        vecs[9]  = '{1'b1, 8'd5, 6'h16, 12'h664, 6'h15, 3'b001};
        vecs[10] = '{1'b1, 8'd5, 6'h16, 12'h66C, 6'h16, 3'b000};

        for (int v = 0; v < 11; v++) begin
            rst_n = vecs[v].rst_n;
            dt    = vecs[v].dt;
            cmd   = vecs[v].cmd;
            tick();
            chk($sformatf("tbl%0d_gate", v),  {20'd0, gate},  {20'd0, vecs[v].gate});
            chk($sformatf("tbl%0d_level", v), {26'd0, level}, {26'd0, vecs[v].level});
            chk($sformatf("tbl%0d_busy", v),  {29'd0, busy},  {29'd0, vecs[v].busy});
            chk($sformatf("tbl%0d_fa", v),    {31'd0, fa},    32'd0);
            chk($sformatf("tbl%0d_err", v),   {29'd0, err},   32'd0);
        end

        // Leg1: bring to P, satisfy dwell, then command N directly (dt=3).
        begin
            logic found;
            dt = 8'd3;
            cmd = 6'h1A;
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                tick();
                if (level[3:2] == 2'b10) found = 1'b1;
            end
            chk("leg1_reach_p", {31'd0, found}, 32'd1);
            for (int t = 0; t < 3; t++) tick();
            cmd = 6'h12;
            exp_g = '{4'h4, 4'h4, 4'h4, 4'h6, 4'h6, 4'h6, 4'h6, 4'h2, 4'h2, 4'h2, 4'h3};
            exp_l = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
            exp_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int t = 0; t < 11; t++) begin
                tick();
                chk($sformatf("pn%0d_gate", t),  {28'd0, gate[7:4]},  {28'd0, exp_g[t]});
                chk($sformatf("pn%0d_level", t), {30'd0, level[3:2]}, {30'd0, exp_l[t]});
                chk($sformatf("pn%0d_busy", t),  {31'd0, busy[1]},    {31'd0, exp_b[t]});
            end
        end

        // Leg2 with dt=0: single-cycle dead interval, then command toggling every cycle.
        begin
            int   last_chg;
            int   min_gap;
            int   n_chg;
            logic prev_busy;
            logic dbl_busy;
            logic [1:0] prev_lvl;
            dt = 8'd0;
            cmd = 6'h22;
            tick();
            chk("dt0_dead_gate", {28'd0, gate[11:8]}, 32'h4);
            chk("dt0_dead_busy", {31'd0, busy[2]}, 32'd1);
            tick();
            chk("dt0_p_gate", {28'd0, gate[11:8]}, 32'hC);
            chk("dt0_p_busy", {31'd0, busy[2]}, 32'd0);
            last_chg = 0; min_gap = 999; n_chg = 0;
            prev_lvl = level[5:4]; prev_busy = busy[2]; dbl_busy = 1'b0;
            for (int t = 1; t <= 40; t++) begin
                cmd[5:4] = t[0] ? 2'b00 : 2'b10;
                tick();
                if (level[5:4] != prev_lvl) begin
                    if (t - last_chg < min_gap) min_gap = t - last_chg;
                    last_chg = t;
                    n_chg++;
                end
                if (busy[2] && prev_busy) dbl_busy = 1'b1;
                prev_lvl  = level[5:4];
                prev_busy = busy[2];
            end
            chk("toggle_changes", {31'd0, n_chg >= 2}, 32'd1);
            chk("toggle_min_gap", {31'd0, min_gap >= 5}, 32'd1);
            chk("toggle_dead_len", {31'd0, dbl_busy}, 32'd0);
        end

        // Settle legs at P / N / O with dt=4, then pulse fault for one cycle.
        dt = 8'd4;
        cmd = 6'h12;
        for (int t = 0; t < 20; t++) tick();
        chk("settle_gate", {20'd0, gate}, 32'h63C);
        chk("settle_level", {26'd0, level}, 32'h12);
        chk("settle_busy", {29'd0, busy}, 32'd0);
        fault = 1'b1;
        tick();
        fault = 1'b0;
        chk("fault_set", {31'd0, fa}, 32'd1);
        chk("fault_edge_gate", {20'd0, gate}, 32'h63C);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("sd%0d_gate", t),  {20'd0, gate},  32'h024);
            chk($sformatf("sd%0d_busy", t),  {29'd0, busy},  32'h3);
            chk($sformatf("sd%0d_level", t), {26'd0, level}, 32'h12);
        end
        tick();
        chk("sd_off_gate", {20'd0, gate}, 32'h000);
        chk("sd_off_busy", {29'd0, busy}, 32'd0);
        chk("sd_off_level", {26'd0, level}, 32'h15);
        for (int t = 0; t < 3; t++) tick();
        chk("fault_sticky", {31'd0, fa}, 32'd1);
        chk("fault_hold_off", {20'd0, gate}, 32'h000);
        cmd = 6'h15;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_clr", {31'd0, fa}, 32'd0);
        chk("clr_edge_gate", {20'd0, gate}, 32'h000);
        tick();
        chk("restart_gate", {20'd0, gate}, 32'h666);

        // Invalid command on leg2.
        cmd = 6'h35;
        tick();
        chk("inv_err", {29'd0, err}, 32'h4);
        chk("inv_gate", {20'd0, gate}, 32'h666);
        for (int t = 0; t < 2; t++) tick();
        chk("inv_hold_gate", {20'd0, gate}, 32'h666);
        cmd = 6'h15;
        tick();
        chk("inv_sticky", {29'd0, err}, 32'h4);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("inv_clr", {29'd0, err}, 32'd0);

        // Reset in the middle of a dead interval.
        cmd = 6'h16;
        tick();
        chk("mid_dead_gate", {20'd0, gate}, 32'h664);
        chk("mid_dead_busy", {29'd0, busy}, 32'h1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_gate", {20'd0, gate}, 32'h000);
        chk("rst_level", {26'd0, level}, 32'h15);
        chk("rst_busy", {29'd0, busy}, 32'd0);
        rst_n = 1'b1;
        cmd = 6'h15;
        tick();
        chk("rst_restart", {20'd0, gate}, 32'h666);

        // fault and fault_clr together: fault wins.
        fault = 1'b1;
        fault_clr = 1'b1;
        tick();
        chk("fault_wins", {31'd0, fa}, 32'd1);
        fault = 1'b0;
        tick();
        chk("clr_alone", {31'd0, fa}, 32'd0);
        fault_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
